// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the regfile writeback path: widths, default buffer
// depth and the layout of one buffered port-B write.
package regfile_ctrl_pkg;

  localparam int DATA_W         = 32;
  localparam int REG_W          = 5;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic              squashed;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Circular buffer of port-B writebacks. A younger port-A write can squash any
// buffered entry to the same register (including one pushed at the same edge)
// so the stale value is dropped when it reaches the head.
module wb_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [REG_W-1:0]  push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash,
  input  logic [REG_W-1:0]  squash_reg,
  output logic [REG_W-1:0]  head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic              head_squashed,
  output logic [PTR_W:0]    count,
  output logic [31:0]       mask
);

  logic [REG_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  squashed_q;
  logic [DEPTH-1:0]  live;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Entry payload storage; liveness is tracked by the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_ptr] <= push_reg;
      data_q[tail_ptr] <= push_data;
    end
  end

  // Squash flags: the later push assignment covers the same-edge collision.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (squash && (addr_q[i] == squash_reg)) squashed_q[i] <= 1'b1;
    end
    if (push) squashed_q[tail_ptr] <= squash && (push_reg == squash_reg);
  end

  // Decode stall mask from live, non-squashed entries.
  always_comb begin
    mask = '0;
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = {1'b0, PTR_W'(PTR_W'(i) - head_ptr)} < count;
      if (live[i] && !squashed_q[i]) mask[addr_q[i]] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign head_reg      = addr_q[head_ptr];
  assign head_data     = data_q[head_ptr];
  assign head_squashed = squashed_q[head_ptr];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges the ALU (port A, never stalled) and multdiv (port B, buffered)
// writebacks onto the single regfile write port. Port A always has priority;
// the buffer drains only in cycles where port A is not writing.
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATA_W     = regfile_ctrl_pkg::DATA_W
) (
  input  logic                        clock,
  input  logic                        ctrl_reset,
  input  logic                        a_valid,
  input  logic [4:0]                  a_reg,
  input  logic [DATA_W-1:0]           a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [4:0]                  b_reg,
  input  logic [DATA_W-1:0]           b_data,
  output logic                        ctrl_writeEnable,
  output logic [4:0]                  ctrl_writeReg,
  output logic [DATA_W-1:0]           data_writeReg,
  output logic [31:0]                 pending_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              a_accept;
  logic              b_accept;
  logic              push;
  logic              pop;
  logic [REG_W-1:0]  head_reg;
  logic [DATA_W-1:0] head_data;
  logic              head_squashed;

  logic              we_p1;
  logic [REG_W-1:0]  reg_p1;
  logic [DATA_W-1:0] data_p1;

  // Writes to r0 are architecturally dead, so they are neither issued nor squash anything.
  assign a_accept = !ctrl_reset && a_valid && (a_reg != '0);
  assign b_ready  = !ctrl_reset && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign b_accept = b_valid && b_ready;
  assign push     = b_accept && (b_reg != '0);
  assign pop      = !ctrl_reset && !a_accept && (fifo_count != '0);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clock        (clock),
    .reset        (ctrl_reset),
    .push         (push),
    .push_reg     (b_reg),
    .push_data    (b_data),
    .pop          (pop),
    .squash       (a_accept),
    .squash_reg   (a_reg),
    .head_reg     (head_reg),
    .head_data    (head_data),
    .head_squashed(head_squashed),
    .count        (fifo_count),
    .mask         (pending_mask)
  );

  // Output stage: one regfile write per cycle, port A first, then a live FIFO head.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_p1   <= 1'b0;
      reg_p1  <= '0;
      data_p1 <= '0;
    end else if (a_accept) begin
      we_p1   <= 1'b1;
      reg_p1  <= a_reg;
      data_p1 <= a_data;
    end else if (pop && !head_squashed) begin
      we_p1   <= 1'b1;
      reg_p1  <= head_reg;
      data_p1 <= head_data;
    end else begin
      we_p1   <= 1'b0;
    end
  end

  assign ctrl_writeEnable = we_p1;
  assign ctrl_writeReg    = reg_p1;
  assign data_writeReg    = data_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with fixed expectations,
// then random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        a_valid, b_valid, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pending_mask;
  logic [1:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending_mask(pending_mask),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of pending port-B writes plus the last write issued.
  wb_entry_t   q[$];
  wb_entry_t   e;
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  bit          m_a_acc, m_b_acc;

  always @(posedge clock) begin
    if (ctrl_reset) begin
      q.delete();
      exp_we = 1'b0; exp_reg = '0; exp_data = '0;
    end else begin
      m_a_acc = a_valid && (a_reg != 0);
      m_b_acc = b_valid && (q.size() < DEPTH);
      exp_we  = 1'b0;
      if (m_a_acc) begin
        exp_we = 1'b1; exp_reg = a_reg; exp_data = a_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.squashed) begin exp_we = 1'b1; exp_reg = e.addr; exp_data = e.data; end
      end
      if (m_b_acc && b_reg != 0) q.push_back('{addr: b_reg, data: b_data, squashed: 1'b0});
      if (m_a_acc) foreach (q[i]) if (q[i].addr == a_reg) q[i].squashed = 1'b1;
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (!q[i].squashed) m[q[i].addr] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    a_valid = v; a_reg = r; a_data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    b_valid = v; b_reg = r; b_data = d;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1; set_a(1'b1, 5'd5, 32'h55); set_b(1'b1, 5'd9, 32'h99);
    #1;
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got=%0b want=0", b_ready); end
    tick(); tick();
    n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b want=0", ctrl_writeEnable); end
    n_checks++; if (ctrl_writeReg !== 5'd0) begin n_fail++; $display("FAIL reset_reg got=%0d want=0", ctrl_writeReg); end
    n_checks++; if (data_writeReg !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%0h want=0", data_writeReg); end
    n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    n_checks++; if (pending_mask !== 32'd0) begin n_fail++; $display("FAIL reset_mask got=%0h want=0", pending_mask); end
    ctrl_reset = 1'b0; set_a(1'b0, 5'd0, 32'd0); set_b(1'b0, 5'd0, 32'd0);
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_b_ready got=%0b want=1", b_ready); end
  endtask

  task automatic test_a_only();
    set_a(1'b1, 5'd5, 32'h12345678);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    n_checks++; if (ctrl_writeEnable !== 1'b1) begin n_fail++; $display("FAIL a_only_we got=%0b want=1", ctrl_writeEnable); end
    n_checks++; if (ctrl_writeReg !== 5'd5) begin n_fail++; $display("FAIL a_only_reg got=%0d want=5", ctrl_writeReg); end
    n_checks++; if (data_writeReg !== 32'h12345678) begin n_fail++; $display("FAIL a_only_data got=%0h want=12345678", data_writeReg); end
    tick();
    n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_fail++; $display("FAIL a_only_we_drop got=%0b want=0", ctrl_writeEnable); end
    n_checks++; if (data_writeReg !== 32'h12345678) begin n_fail++; $display("FAIL a_only_data_hold got=%0h want=12345678", data_writeReg); end
  endtask

  task automatic test_b_drain();
    set_b(1'b1, 5'd7, 32'hA);
    tick();
    set_b(1'b0, 5'd0, 32'd0);
    n_checks++; if (fifo_count !== 2'd1) begin n_fail++; $display("FAIL drain_count got=%0d want=1", fifo_count); end
    n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_fail++; $display("FAIL drain_we_idle got=%0b want=0", ctrl_writeEnable); end
    for (int r = 1; r <= 3; r++) begin
      set_a(1'b1, 5'(r), 32'(r * 16));
      tick();
      n_checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'(r)) begin n_fail++; $display("FAIL drain_a_write got=%0b/%0d want=1/%0d", ctrl_writeEnable, ctrl_writeReg, r); end
      n_checks++; if (pending_mask !== 32'h80) begin n_fail++; $display("FAIL drain_mask_held got=%0h want=80", pending_mask); end
    end
    set_a(1'b0, 5'd0, 32'd0);
    tick();
    n_checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || data_writeReg !== 32'hA) begin n_fail++; $display("FAIL drain_b_write got=%0b/%0d/%0h want=1/7/a", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
    n_checks++; if (pending_mask !== 32'd0 || fifo_count !== 2'd0) begin n_fail++; $display("FAIL drain_empty got=%0h/%0d want=0/0", pending_mask, fifo_count); end
  endtask

  task automatic test_fifo_full();
    set_a(1'b1, 5'd1, 32'h1); set_b(1'b1, 5'd8, 32'h80);
    tick();
    set_a(1'b1, 5'd2, 32'h2); set_b(1'b1, 5'd9, 32'h90);
    tick();
    n_checks++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL full_count got=%0d want=2", fifo_count); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL full_b_ready got=%0b want=0", b_ready); end
    n_checks++; if (pending_mask !== 32'h300) begin n_fail++; $display("FAIL full_mask got=%0h want=300", pending_mask); end
    set_a(1'b1, 5'd3, 32'h3); set_b(1'b1, 5'd10, 32'hA0);
    tick();
    n_checks++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL full_hold_count got=%0d want=2", fifo_count); end
    set_a(1'b0, 5'd0, 32'd0);
    tick();
    n_checks++; if (ctrl_writeReg !== 5'd8 || data_writeReg !== 32'h80 || ctrl_writeEnable !== 1'b1) begin n_fail++; $display("FAIL full_pop1 got=%0d/%0h want=8/80", ctrl_writeReg, data_writeReg); end
    n_checks++; if (b_ready !== 1'b1 || fifo_count !== 2'd1) begin n_fail++; $display("FAIL full_reopen got=%0b/%0d want=1/1", b_ready, fifo_count); end
    tick();
    set_b(1'b0, 5'd0, 32'd0);
    n_checks++; if (ctrl_writeReg !== 5'd9 || ctrl_writeEnable !== 1'b1) begin n_fail++; $display("FAIL full_pop2 got=%0d want=9", ctrl_writeReg); end
    n_checks++; if (fifo_count !== 2'd1 || pending_mask !== 32'h400) begin n_fail++; $display("FAIL full_push_pop got=%0d/%0h want=1/400", fifo_count, pending_mask); end
    tick();
    n_checks++; if (ctrl_writeReg !== 5'd10 || data_writeReg !== 32'hA0 || fifo_count !== 2'd0) begin n_fail++; $display("FAIL full_pop3 got=%0d/%0h/%0d want=10/a0/0", ctrl_writeReg, data_writeReg, fifo_count); end
  endtask

  task automatic test_squash();
    set_b(1'b1, 5'd4, 32'h1);
    tick();
    set_b(1'b0, 5'd0, 32'd0);
    n_checks++; if (pending_mask !== 32'h10) begin n_fail++; $display("FAIL squash_mask_set got=%0h want=10", pending_mask); end
    set_a(1'b1, 5'd4, 32'h2);
    tick();
    set_a(1'b0, 5'd0, 32'd0);
    n_checks++; if (ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h2 || ctrl_writeEnable !== 1'b1) begin n_fail++; $display("FAIL squash_a_write got=%0d/%0h want=4/2", ctrl_writeReg, data_writeReg); end
    n_checks++; if (pending_mask !== 32'd0 || fifo_count !== 2'd1) begin n_fail++; $display("FAIL squash_mask_clr got=%0h/%0d want=0/1", pending_mask, fifo_count); end
    tick();
    n_checks++; if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0) begin n_fail++; $display("FAIL squash_pop got=%0b/%0d want=0/0", ctrl_writeEnable, fifo_count); end
    n_checks++; if (data_writeReg !== 32'h2) begin n_fail++; $display("FAIL squash_data_hold got=%0h want=2", data_writeReg); end
  endtask

  task automatic test_simultaneous();
    set_a(1'b1, 5'd6, 32'h3); set_b(1'b1, 5'd6, 32'h4);
    tick();
    set_a(1'b0, 5'd0, 32'd0); set_b(1'b0, 5'd0, 32'd0);
    n_checks++; if (ctrl_writeReg !== 5'd6 || data_writeReg !== 32'h3) begin n_fail++; $display("FAIL simul_a_wins got=%0d/%0h want=6/3", ctrl_writeReg, data_writeReg); end
    n_checks++; if (pending_mask !== 32'd0) begin n_fail++; $display("FAIL simul_mask got=%0h want=0", pending_mask); end
    tick();
    n_checks++; if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0) begin n_fail++; $display("FAIL simul_b_dropped got=%0b/%0d want=0/0", ctrl_writeEnable, fifo_count); end
    set_a(1'b1, 5'd0, 32'h77); set_b(1'b1, 5'd0, 32'h88);
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL r0_handshake got=%0b want=1", b_ready); end
    tick();
    set_a(1'b0, 5'd0, 32'd0); set_b(1'b0, 5'd0, 32'd0);
    n_checks++; if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0) begin n_fail++; $display("FAIL r0_no_write got=%0b/%0d want=0/0", ctrl_writeEnable, fifo_count); end
  endtask

  task automatic test_reset_mid();
    set_a(1'b1, 5'd1, 32'h11); set_b(1'b1, 5'd11, 32'hB1);
    tick();
    set_a(1'b1, 5'd2, 32'h22); set_b(1'b1, 5'd12, 32'hB2);
    tick();
    set_a(1'b0, 5'd0, 32'd0); set_b(1'b0, 5'd0, 32'd0);
    n_checks++; if (fifo_count !== 2'd2) begin n_fail++; $display("FAIL rmid_count_pre got=%0d want=2", fifo_count); end
    ctrl_reset = 1'b1;
    tick();
    n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_fail++; $display("FAIL rmid_we got=%0b want=0", ctrl_writeEnable); end
    n_checks++; if (fifo_count !== 2'd0 || pending_mask !== 32'd0) begin n_fail++; $display("FAIL rmid_flush got=%0d/%0h want=0/0", fifo_count, pending_mask); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_b_ready_in_reset got=%0b want=0", b_ready); end
    ctrl_reset = 1'b0;
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_b_ready_after got=%0b want=1", b_ready); end
    tick();
    n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_fail++; $display("FAIL rmid_no_ghost got=%0b want=0", ctrl_writeEnable); end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int c = 0; c < 400; c++) begin
      ctrl_reset = ($urandom_range(0, 49) == 0);
      set_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      set_b(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      #1;
      exp_rdy = !ctrl_reset && (q.size() < DEPTH);
      n_checks++; if (b_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_b_ready c=%0d got=%0b want=%0b", c, b_ready, exp_rdy); end
      tick();
      n_checks++; if (ctrl_writeEnable !== exp_we) begin n_fail++; $display("FAIL rand_we c=%0d got=%0b want=%0b", c, ctrl_writeEnable, exp_we); end
      n_checks++; if (ctrl_writeReg !== exp_reg || data_writeReg !== exp_data) begin n_fail++; $display("FAIL rand_write c=%0d got=%0d/%0h want=%0d/%0h", c, ctrl_writeReg, data_writeReg, exp_reg, exp_data); end
      n_checks++; if (fifo_count !== 2'(q.size())) begin n_fail++; $display("FAIL rand_count c=%0d got=%0d want=%0d", c, fifo_count, q.size()); end
      n_checks++; if (pending_mask !== model_mask()) begin n_fail++; $display("FAIL rand_mask c=%0d got=%0h want=%0h", c, pending_mask, model_mask()); end
    end
    ctrl_reset = 1'b0; set_a(1'b0, 5'd0, 32'd0); set_b(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_drain();
    test_fifo_full();
    test_squash();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, the number of buffered port-B writes (power of two, at least 2).
REQ-002 SHALL have parameter DATA_W, default 32, the register data width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ctrl_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port a_valid, input, 1 bit: ALU writeback request; always accepted, never stalled.
REQ-006 SHALL have port a_reg, input, 5 bits: ALU destination register.
REQ-007 SHALL have port a_data, input, DATA_W bits: ALU write data.
REQ-008 SHALL have port b_valid, input, 1 bit: multdiv writeback request.
REQ-009 SHALL have port b_ready, output, 1 bit: the port-B request is accepted this cycle when b_valid and b_ready are both high.
REQ-010 SHALL have port b_reg, input, 5 bits: multdiv destination register.
REQ-011 SHALL have port b_data, input, DATA_W bits: multdiv write data.
REQ-012 SHALL have port ctrl_writeEnable, output, 1 bit: registered regfile write enable.
REQ-013 SHALL have port ctrl_writeReg, output, 5 bits: registered regfile write address.
REQ-014 SHALL have port data_writeReg, output, DATA_W bits: registered regfile write data.
REQ-015 SHALL have port pending_mask, output, 32 bits: bit r is high when a live buffered write targets register r; used by decode to stall.
REQ-016 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1 bits: current occupancy of the port-B buffer.

Function
REQ-017 SHALL accept port A at the edge when a_valid=1 and a_reg!=0. The write then appears on ctrl_writeEnable, ctrl_writeReg and data_writeReg in the following cycle (latency 1).
REQ-018 SHALL ignore port A when a_reg=0: no write is issued and the squash rule in REQ-021 does not apply.
REQ-019 SHALL drive b_ready = (fifo_count < FIFO_DEPTH) from the registered count only. A pop in the same cycle does not raise b_ready.
REQ-020 SHALL handle a port-B handshake as follows: b_reg!=0 enqueues {reg, data, squashed=0} at the tail; b_reg=0 completes the handshake but enqueues nothing.
REQ-021 SHALL, on an accepted port-A write to register r, set squashed=1 on every buffered entry targeting r. This includes an entry enqueued at the same edge: port A is younger and wins.
REQ-022 SHALL pop the FIFO head at an edge only when port A is not accepted at that edge and fifo_count>0.
REQ-023 SHALL handle a pop as follows: a non-squashed head produces a write in the next cycle with latency 1; a squashed head is discarded, issues no write, and still consumes the slot.
REQ-024 SHALL, for a simultaneous enqueue and pop, update fifo_count by net 0 and leave FIFO order FIFO-preserving.
REQ-025 SHALL drive ctrl_writeEnable high for exactly one cycle per issued write, and low in every cycle with no issued write. ctrl_writeReg and data_writeReg hold their last values while the enable is low.
REQ-026 SHALL never issue a write to register 0.
REQ-027 SHALL compute pending_mask combinationally from buffered entries with squashed=0; bit 0 SHALL always be 0.
REQ-028 SHALL wrap the head and tail pointers modulo FIFO_DEPTH.
REQ-029 SHALL issue a port-B write at most once and never reorder port-B writes among themselves.

Reset
REQ-030 SHALL, when ctrl_reset=1 at an edge, produce: FIFO empty, fifo_count=0, pointers=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
REQ-031 SHALL force b_ready=0 while ctrl_reset is high and ignore a_valid and b_valid in those cycles.
REQ-032 SHALL, on reset mid-operation, discard buffered entries and issue no write in the cycle after the reset edge.
REQ-033 SHALL drive pending_mask=0 from the cycle after the reset edge.

Structure
REQ-034 SHALL place DATA_W, the register address width (5), the default FIFO_DEPTH and the buffered-entry record {reg, data, squashed} in shared package regfile_ctrl_pkg.
REQ-035 SHALL implement the buffer as sub-module wb_fifo: circular buffer with push, pop, a per-entry squash-by-address input, and head, count and mask outputs. Arbitration and the output registers SHALL live in the top module.

Verification
REQ-036 SHALL verify A-only: a_valid, r5, 0x12345678 at edge N -> ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x12345678 in cycle N+1 only.
REQ-037 SHALL verify B drain under A pressure: B r7 = 0xA, then A valid for 3 cycles (r1..r3) -> r1, r2, r3 written, then r7 = 0xA in the next cycle; pending_mask[7]=1 until the pop.
REQ-038 SHALL verify FIFO full: B pushes r8 and r9 while A is busy -> fifo_count=2 and b_ready=0; a third b_valid is held; after one pop b_ready=1 the next cycle.
REQ-039 SHALL verify squash: B r4 = 0x1 buffered, then A r4 = 0x2 -> only 0x2 is written to r4; pending_mask[4] clears at the A edge; the squashed pop issues no write.
REQ-040 SHALL verify simultaneous events: A r6 = 0x3 and B r6 = 0x4 at the same edge -> r6 = 0x3 only; A r0 or B r0 -> no write, B handshake completes.
REQ-041 SHALL verify reset mid-operation: 2 entries buffered, ctrl_reset pulsed -> no write the next cycle; fifo_count=0, pending_mask=0; b_ready=1 after reset deasserts.
